// File: rtl/svc_mem_sram_ldst.sv
// svc_mem_sram_ldst: two-stage load/store front end for a zero-latency SRAM.
//
// S1 (issue) holds one accepted request and drives the SRAM for one cycle.
// S2 (response) holds one response until the consumer takes it.
// An accepted request produces its response one edge after acceptance.
//
// Ports:
//   clk, rst_n                  clock, asynchronous active-low reset
//   req_valid/req_ready         request handshake
//   req_write                   1 = store, 0 = load
//   req_addr, req_size          byte address; size 00 byte, 01 half, 10 word, 11 illegal
//   req_signed                  sign-extend loads
//   req_wdata                   right-justified store data
//   rsp_valid/rsp_ready         response handshake
//   rsp_rdata, rsp_err          extended load data (0 for stores/errors), error flag
//   sram_rd_addr, sram_rd_data  word-aligned combinational read port
//   sram_wr_*                   word-aligned strobed write port
module svc_mem_sram_ldst #(
  parameter int unsigned AW = 32
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          req_valid,
  output logic          req_ready,
  input  logic          req_write,
  input  logic [AW-1:0] req_addr,
  input  logic [1:0]    req_size,
  input  logic          req_signed,
  input  logic [31:0]   req_wdata,
  output logic          rsp_valid,
  input  logic          rsp_ready,
  output logic [31:0]   rsp_rdata,
  output logic          rsp_err,
  output logic [AW-1:0] sram_rd_addr,
  input  logic [31:0]   sram_rd_data,
  output logic [AW-1:0] sram_wr_addr,
  output logic [31:0]   sram_wr_data,
  output logic [3:0]    sram_wr_strb,
  output logic          sram_wr_en
);

  // Issue stage
  logic          s1_valid_q, s1_valid_d;
  logic          s1_write_q, s1_write_d;
  logic [AW-1:0] s1_addr_q, s1_addr_d;
  logic [1:0]    s1_size_q, s1_size_d;
  logic          s1_signed_q, s1_signed_d;
  logic [31:0]   s1_wdata_q, s1_wdata_d;
  logic          s1_err_q, s1_err_d;

  // Response stage
  logic          s2_valid_q, s2_valid_d;
  logic [31:0]   s2_rdata_q, s2_rdata_d;
  logic          s2_err_q, s2_err_d;

  logic          s1_advance;
  logic          req_err;
  logic          req_fire;
  logic [31:0]   rd_shifted;
  logic [31:0]   load_data;

  assign s1_advance = s1_valid_q && (!s2_valid_q || rsp_ready);
  assign req_ready  = !s1_valid_q || s1_advance;
  assign req_fire   = req_valid && req_ready;

  always_comb begin
    req_err = 1'b0;
    unique case (req_size)
      2'b00:   req_err = 1'b0;
      2'b01:   req_err = req_addr[0];
      2'b10:   req_err = (req_addr[1:0] != 2'b00);
      default: req_err = 1'b1;
    endcase
  end

  // Bring the addressed lane down to bit 0, then extend by size.
  assign rd_shifted = sram_rd_data >> {s1_addr_q[1:0], 3'b000};

  always_comb begin
    load_data = 32'h0;
    unique case (s1_size_q)
      2'b00:   load_data = {{24{s1_signed_q & rd_shifted[7]}}, rd_shifted[7:0]};
      2'b01:   load_data = {{16{s1_signed_q & rd_shifted[15]}}, rd_shifted[15:0]};
      2'b10:   load_data = sram_rd_data;
      default: load_data = 32'h0;
    endcase
  end

  always_comb begin
    s1_valid_d  = s1_valid_q;
    s1_write_d  = s1_write_q;
    s1_addr_d   = s1_addr_q;
    s1_size_d   = s1_size_q;
    s1_signed_d = s1_signed_q;
    s1_wdata_d  = s1_wdata_q;
    s1_err_d    = s1_err_q;
    if (req_ready) begin
      s1_valid_d = req_valid;
    end
    if (req_fire) begin
      s1_write_d  = req_write;
      s1_addr_d   = req_addr;
      s1_size_d   = req_size;
      s1_signed_d = req_signed;
      s1_wdata_d  = req_wdata;
      s1_err_d    = req_err;
    end
  end

  always_comb begin
    s2_valid_d = s2_valid_q;
    s2_rdata_d = s2_rdata_q;
    s2_err_d   = s2_err_q;
    if (s1_advance) begin
      s2_valid_d = 1'b1;
      s2_err_d   = s1_err_q;
      s2_rdata_d = (s1_write_q || s1_err_q) ? 32'h0 : load_data;
    end else if (rsp_ready) begin
      s2_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid_q  <= 1'b0;
      s1_write_q  <= 1'b0;
      s1_addr_q   <= '0;
      s1_size_q   <= 2'b00;
      s1_signed_q <= 1'b0;
      s1_wdata_q  <= 32'h0;
      s1_err_q    <= 1'b0;
      s2_valid_q  <= 1'b0;
      s2_rdata_q  <= 32'h0;
      s2_err_q    <= 1'b0;
    end else begin
      s1_valid_q  <= s1_valid_d;
      s1_write_q  <= s1_write_d;
      s1_addr_q   <= s1_addr_d;
      s1_size_q   <= s1_size_d;
      s1_signed_q <= s1_signed_d;
      s1_wdata_q  <= s1_wdata_d;
      s1_err_q    <= s1_err_d;
      s2_valid_q  <= s2_valid_d;
      s2_rdata_q  <= s2_rdata_d;
      s2_err_q    <= s2_err_d;
    end
  end

  assign sram_rd_addr = {s1_addr_q[AW-1:2], 2'b00};
  assign sram_wr_addr = {s1_addr_q[AW-1:2], 2'b00};
  // Write only on the advance edge so a stalled store cannot write twice.
  assign sram_wr_en   = s1_valid_q && s1_write_q && !s1_err_q && s1_advance;

  always_comb begin
    sram_wr_strb = 4'b0000;
    sram_wr_data = 32'h0;
    if (s1_valid_q) begin
      unique case (s1_size_q)
        2'b00: begin
          sram_wr_strb = 4'b0001 << s1_addr_q[1:0];
          sram_wr_data = {4{s1_wdata_q[7:0]}};
        end
        2'b01: begin
          sram_wr_strb = s1_addr_q[1] ? 4'b1100 : 4'b0011;
          sram_wr_data = {2{s1_wdata_q[15:0]}};
        end
        2'b10: begin
          sram_wr_strb = 4'b1111;
          sram_wr_data = s1_wdata_q;
        end
        default: begin
          sram_wr_strb = 4'b0000;
          sram_wr_data = 32'h0;
        end
      endcase
    end
  end

  assign rsp_valid = s2_valid_q;
  assign rsp_rdata = s2_rdata_q;
  assign rsp_err   = s2_err_q;

endmodule

// File: tb/tb_svc_mem_sram_ldst.sv
module tb_svc_mem_sram_ldst;

  localparam int unsigned AW = 10;

  logic          clk;
  logic          rst_n;
  logic          req_valid;
  logic          req_ready;
  logic          req_write;
  logic [AW-1:0] req_addr;
  logic [1:0]    req_size;
  logic          req_signed;
  logic [31:0]   req_wdata;
  logic          rsp_valid;
  logic          rsp_ready;
  logic [31:0]   rsp_rdata;
  logic          rsp_err;
  logic [AW-1:0] sram_rd_addr;
  logic [31:0]   sram_rd_data;
  logic [AW-1:0] sram_wr_addr;
  logic [31:0]   sram_wr_data;
  logic [3:0]    sram_wr_strb;
  logic          sram_wr_en;

  int n_cmp;
  int n_fail;
  int wr_cnt;
  int wr_snap;

  logic [31:0] mem [256];

  svc_mem_sram_ldst #(.AW(AW)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .req_valid    (req_valid),
    .req_ready    (req_ready),
    .req_write    (req_write),
    .req_addr     (req_addr),
    .req_size     (req_size),
    .req_signed   (req_signed),
    .req_wdata    (req_wdata),
    .rsp_valid    (rsp_valid),
    .rsp_ready    (rsp_ready),
    .rsp_rdata    (rsp_rdata),
    .rsp_err      (rsp_err),
    .sram_rd_addr (sram_rd_addr),
    .sram_rd_data (sram_rd_data),
    .sram_wr_addr (sram_wr_addr),
    .sram_wr_data (sram_wr_data),
    .sram_wr_strb (sram_wr_strb),
    .sram_wr_en   (sram_wr_en)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Zero-latency SRAM with byte strobes.
  assign sram_rd_data = mem[sram_rd_addr[9:2]];

  always @(posedge clk) begin
    if (sram_wr_en) begin
      wr_cnt <= wr_cnt + 1;
      for (int b = 0; b < 4; b++) begin
        if (sram_wr_strb[b]) mem[sram_wr_addr[9:2]][b*8 +: 8] <= sram_wr_data[b*8 +: 8];
      end
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // One complete transaction with rsp_ready held high; checks acceptance,
  // fixed latency and the response contents.
  task automatic xact(input string tag, input logic w, input logic [AW-1:0] a,
                      input logic [1:0] sz, input logic sg, input logic [31:0] wd,
                      input logic [31:0] exp_d, input logic exp_e);
    int n;
    @(negedge clk);
    req_valid  = 1'b1;
    req_write  = w;
    req_addr   = a;
    req_size   = sz;
    req_signed = sg;
    req_wdata  = wd;
    n = 0;
    while (!req_ready && n < 10) begin
      @(negedge clk);
      n++;
    end
    check({tag, "/accept"}, {31'h0, req_ready}, 32'h1);
    @(posedge clk);
    #1 req_valid = 1'b0;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!rsp_valid && n < 10);
    check({tag, "/rsp_valid"}, {31'h0, rsp_valid}, 32'h1);
    check({tag, "/latency"}, n, 32'd2);
    check({tag, "/rdata"}, rsp_rdata, exp_d);
    check({tag, "/err"}, {31'h0, rsp_err}, {31'h0, exp_e});
  endtask

  task automatic drive(input logic w, input logic [AW-1:0] a, input logic [1:0] sz,
                       input logic sg, input logic [31:0] wd);
    req_valid  = 1'b1;
    req_write  = w;
    req_addr   = a;
    req_size   = sz;
    req_signed = sg;
    req_wdata  = wd;
  endtask

  initial begin
    n_cmp      = 0;
    n_fail     = 0;
    wr_cnt     = 0;
    rst_n      = 1'b0;
    req_valid  = 1'b0;
    req_write  = 1'b0;
    req_addr   = '0;
    req_size   = 2'b00;
    req_signed = 1'b0;
    req_wdata  = 32'h0;
    rsp_ready  = 1'b1;
    for (int i = 0; i < 256; i++) mem[i] = 32'h0;

    // Reset state
    @(negedge clk);
    check("rst/rsp_valid", {31'h0, rsp_valid}, 32'h0);
    check("rst/rsp_rdata", rsp_rdata, 32'h0);
    check("rst/rsp_err", {31'h0, rsp_err}, 32'h0);
    check("rst/wr_en", {31'h0, sram_wr_en}, 32'h0);
    check("rst/wr_strb", {28'h0, sram_wr_strb}, 32'h0);
    check("rst/rd_addr", {22'h0, sram_rd_addr}, 32'h0);
    check("rst/wr_addr", {22'h0, sram_wr_addr}, 32'h0);
    check("rst/wr_data", sram_wr_data, 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check("rst/req_ready", {31'h0, req_ready}, 32'h1);

    // Word store then load
    xact("st_w0", 1'b1, 10'h000, 2'b10, 1'b0, 32'hDEADBEEF, 32'h0, 1'b0);
    xact("ld_w0", 1'b0, 10'h000, 2'b10, 1'b0, 32'h0, 32'hDEADBEEF, 1'b0);

    // Byte stores assemble a word; upper data bits must be ignored
    xact("st_b13", 1'b1, 10'h013, 2'b00, 1'b0, 32'h123456AA, 32'h0, 1'b0);
    xact("st_b12", 1'b1, 10'h012, 2'b00, 1'b0, 32'h000000BB, 32'h0, 1'b0);
    xact("st_b11", 1'b1, 10'h011, 2'b00, 1'b0, 32'h000000CC, 32'h0, 1'b0);
    xact("st_b10", 1'b1, 10'h010, 2'b00, 1'b0, 32'hFFFFFFDD, 32'h0, 1'b0);
    xact("ld_w10", 1'b0, 10'h010, 2'b10, 1'b0, 32'h0, 32'hAABBCCDD, 1'b0);
    xact("ld_sb13", 1'b0, 10'h013, 2'b00, 1'b1, 32'h0, 32'hFFFFFFAA, 1'b0);
    xact("ld_ub13", 1'b0, 10'h013, 2'b00, 1'b0, 32'h0, 32'h000000AA, 1'b0);
    xact("ld_sb11", 1'b0, 10'h011, 2'b00, 1'b1, 32'h0, 32'hFFFFFFCC, 1'b0);

    // Halfword store to the upper lane
    xact("st_h22", 1'b1, 10'h022, 2'b01, 1'b0, 32'h00008001, 32'h0, 1'b0);
    xact("ld_sh22", 1'b0, 10'h022, 2'b01, 1'b1, 32'h0, 32'hFFFF8001, 1'b0);
    xact("ld_uh22", 1'b0, 10'h022, 2'b01, 1'b0, 32'h0, 32'h00008001, 1'b0);
    xact("ld_w20", 1'b0, 10'h020, 2'b10, 1'b0, 32'h0, 32'h80010000, 1'b0);
    xact("ld_sh10", 1'b0, 10'h010, 2'b01, 1'b1, 32'h0, 32'hFFFFCCDD, 1'b0);

    // Back-to-back store then load to the same word
    @(negedge clk);
    drive(1'b1, 10'h030, 2'b10, 1'b0, 32'h00000001);
    check("b2b/ready0", {31'h0, req_ready}, 32'h1);
    @(posedge clk);
    #1 drive(1'b0, 10'h030, 2'b10, 1'b0, 32'h0);
    @(negedge clk);
    check("b2b/ready1", {31'h0, req_ready}, 32'h1);
    @(posedge clk);
    #1 req_valid = 1'b0;
    @(negedge clk);
    check("b2b/st_valid", {31'h0, rsp_valid}, 32'h1);
    check("b2b/st_rdata", rsp_rdata, 32'h0);
    check("b2b/ready2", {31'h0, req_ready}, 32'h1);
    @(negedge clk);
    check("b2b/ld_valid", {31'h0, rsp_valid}, 32'h1);
    check("b2b/ld_rdata", rsp_rdata, 32'h00000001);
    check("b2b/ld_err", {31'h0, rsp_err}, 32'h0);

    // Error requests: no write, zero data
    wr_snap = wr_cnt;
    xact("err_w41", 1'b1, 10'h041, 2'b10, 1'b0, 32'h55555555, 32'h0, 1'b1);
    check("err_w41/no_write", wr_cnt, wr_snap);
    xact("ld_w40", 1'b0, 10'h040, 2'b10, 1'b0, 32'h0, 32'h0, 1'b0);
    xact("err_h23", 1'b0, 10'h023, 2'b01, 1'b1, 32'h0, 32'h0, 1'b1);
    xact("err_sz3", 1'b0, 10'h000, 2'b11, 1'b0, 32'h0, 32'h0, 1'b1);
    wr_snap = wr_cnt;
    xact("err_sth21", 1'b1, 10'h021, 2'b01, 1'b0, 32'hFFFF, 32'h0, 1'b1);
    check("err_sth21/no_write", wr_cnt, wr_snap);
    xact("ld_w20b", 1'b0, 10'h020, 2'b10, 1'b0, 32'h0, 32'h80010000, 1'b0);

    // Backpressure: A=load, B=store, C=load of B's word
    @(negedge clk);
    rsp_ready = 1'b0;
    drive(1'b0, 10'h000, 2'b10, 1'b0, 32'h0);
    check("bp/ready_a", {31'h0, req_ready}, 32'h1);
    @(posedge clk);
    #1 drive(1'b1, 10'h050, 2'b10, 1'b0, 32'h12345678);
    @(negedge clk);
    check("bp/ready_b", {31'h0, req_ready}, 32'h1);
    @(posedge clk);
    #1 drive(1'b0, 10'h050, 2'b10, 1'b0, 32'h0);
    wr_snap = wr_cnt;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      check("bp/ready_stall", {31'h0, req_ready}, 32'h0);
      check("bp/hold_valid", {31'h0, rsp_valid}, 32'h1);
      check("bp/hold_rdata", rsp_rdata, 32'hDEADBEEF);
      check("bp/hold_err", {31'h0, rsp_err}, 32'h0);
      check("bp/no_wr_en", {31'h0, sram_wr_en}, 32'h0);
    end
    rsp_ready = 1'b1;
    #1 check("bp/ready_c", {31'h0, req_ready}, 32'h1);
    @(posedge clk);
    #1 req_valid = 1'b0;
    check("bp/one_write", wr_cnt, wr_snap + 1);
    @(negedge clk);
    check("bp/rsp_b_valid", {31'h0, rsp_valid}, 32'h1);
    check("bp/rsp_b_rdata", rsp_rdata, 32'h0);
    @(negedge clk);
    check("bp/rsp_c_valid", {31'h0, rsp_valid}, 32'h1);
    check("bp/rsp_c_rdata", rsp_rdata, 32'h12345678);
    @(negedge clk);
    check("bp/drained", {31'h0, rsp_valid}, 32'h0);

    // Reset while a store sits in S1 must drop it
    @(negedge clk);
    drive(1'b1, 10'h060, 2'b10, 1'b0, 32'hFFFFFFFF);
    wr_snap = wr_cnt;
    @(posedge clk);
    #1 req_valid = 1'b0;
    rst_n = 1'b0;
    #1 check("mrst/wr_en", {31'h0, sram_wr_en}, 32'h0);
    check("mrst/rsp_valid", {31'h0, rsp_valid}, 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    check("mrst/no_write", wr_cnt, wr_snap);
    xact("mrst/ld_w60", 1'b0, 10'h060, 2'b10, 1'b0, 32'h0, 32'h0, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
